// File: rtl/mbtrain_substate_sequencer_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mbtrain_pkg
// Description : Shared definitions for the MBTRAIN sub-state sequencer:
//               FSM state encodings, sub-state index constants and the
//               sideband message code width.
// Revision    : 1.0 - initial release
//==============================================================================
package mbtrain_pkg;

  // Sequencer FSM states. The encoding is visible on o_state for debug.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } mbtrain_state_e;

  // Sub-state indices, in sequencing order.
  localparam int SUB_VALVREF        = 0;
  localparam int SUB_DATAVREF       = 1;
  localparam int SUB_SPEEDIDLE      = 2;
  localparam int SUB_TXSELFCAL      = 3;
  localparam int SUB_RXCLKCAL       = 4;
  localparam int SUB_VALTRAINCENTER = 5;

  // Width of a sideband message code.
  localparam int SB_MSG_W = 4;

endpackage : mbtrain_pkg
`default_nettype wire

// File: rtl/mbtrain_substate_sequencer_timeout_counter.sv
`default_nettype none
//==============================================================================
// Module      : mbtrain_timeout_counter
// Description : Per-sub-state watchdog. Counts enabled cycles and flags when
//               the count reaches TIMEOUT_CYCLES-1. Saturates there.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               i_clr       - synchronous clear (wins over i_inc)
//               i_inc       - advance the count by one
//               o_expired   - count == TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
//==============================================================================
module mbtrain_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == C_LAST);
  assign o_expired = w_at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : mbtrain_timeout_counter
`default_nettype wire

// File: rtl/mbtrain_substate_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : mbtrain_substate_sequencer
// Description : MBTRAIN controller. Enables the sub-state wrappers one at a
//               time in fixed order (VALVREF .. VALTRAINCENTER), watches each
//               for done / error / timeout, and arbitrates the single sideband
//               transmit path with a one-entry hold buffer.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               i_en                  - MBTRAIN entered; low aborts
//               i_sub_done/error      - per-sub-state status levels
//               i_sub_valid/msg       - per-sub-state sideband requests
//               i_busy                - sideband transmitter busy
//               o_sub_en              - one-hot wrapper enable
//               o_mainband_or_valtrain_test - VALVREF or VALTRAINCENTER active
//               o_sideband_message, o_valid - sideband message and strobe
//               o_done, o_error, o_timeout  - sequence outcome
//               o_sb_overflow         - sticky message-dropped flag
//               o_state               - FSM state for debug
// Revision    : 1.0 - initial release
//==============================================================================
module mbtrain_substate_sequencer
  import mbtrain_pkg::*;
#(
  parameter int N_SUB          = 6,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic [N_SUB-1:0]          i_sub_done,
  input  logic [N_SUB-1:0]          i_sub_error,
  input  logic [N_SUB-1:0]          i_sub_valid,
  input  logic [SB_MSG_W*N_SUB-1:0] i_sub_msg,
  input  logic                      i_busy,
  output logic [N_SUB-1:0]          o_sub_en,
  output logic                      o_mainband_or_valtrain_test,
  output logic [SB_MSG_W-1:0]       o_sideband_message,
  output logic                      o_valid,
  output logic                      o_done,
  output logic                      o_error,
  output logic                      o_timeout,
  output logic                      o_sb_overflow,
  output logic [2:0]                o_state
);

  localparam int IW = (N_SUB > 1) ? $clog2(N_SUB) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(N_SUB - 1);

  mbtrain_state_e      r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic                w_timeout_hit;
  logic                w_expired;
  logic                w_tmr_clr, w_tmr_inc;
  logic                w_cur_done, w_cur_err, w_cur_valid;
  logic [SB_MSG_W-1:0] w_cur_msg;
  logic                w_accept;
  logic [N_SUB-1:0]    w_sub_en_nxt;
  logic                w_mb_nxt;

  logic [N_SUB-1:0]    r_sub_en;
  logic                r_mb;
  logic                r_done, r_error, r_timeout;
  logic [SB_MSG_W-1:0] r_msg;
  logic                r_valid;
  logic                r_ovf;
  logic                r_pend_vld;
  logic [SB_MSG_W-1:0] r_pend_msg;

  // Only the active sub-state's status and request lines are looked at.
  assign w_cur_done  = i_sub_done[r_idx];
  assign w_cur_err   = i_sub_error[r_idx];
  assign w_cur_valid = i_sub_valid[r_idx];
  assign w_cur_msg   = i_sub_msg[SB_MSG_W*int'(r_idx) +: SB_MSG_W];

  // Aborting cycles accept nothing: the buffer is being flushed anyway.
  assign w_accept = i_en && (r_state == ST_RUN) && w_cur_valid;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_timeout_hit = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
        end
        ST_RUN: begin
          // error > done > timeout
          if (w_cur_err) begin
            w_state_nxt = ST_ERROR;
          end else if (w_cur_done) begin
            w_state_nxt = (r_idx == C_LAST_IDX) ? ST_DONE : ST_GAP;
          end else if (w_expired) begin
            w_state_nxt   = ST_ERROR;
            w_timeout_hit = 1'b1;
          end
        end
        ST_GAP: begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = r_idx + 1'b1;
        end
        ST_DONE, ST_ERROR: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Timer runs only while staying in RUN; any other state leaves it at zero,
  // so every RUN entry starts a fresh count.
  assign w_tmr_clr = !i_en || (r_state != ST_RUN);
  assign w_tmr_inc = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);

  mbtrain_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_tmr_clr),
    .i_inc     (w_tmr_inc),
    .o_expired (w_expired)
  );

  //--------------------------------------------------------------------------
  // Registered status outputs, derived from the next state so they line up
  // with the state they describe.
  //--------------------------------------------------------------------------
  assign w_sub_en_nxt = (w_state_nxt == ST_RUN) ? (N_SUB'(1) << w_idx_nxt) : '0;
  assign w_mb_nxt     = (w_state_nxt == ST_RUN) &&
                        ((int'(w_idx_nxt) == SUB_VALVREF) ||
                         (int'(w_idx_nxt) == SUB_VALTRAINCENTER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_en  <= '0;
      r_mb      <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sub_en  <= w_sub_en_nxt;
      r_mb      <= w_mb_nxt;
      r_done    <= (w_state_nxt == ST_DONE);
      r_error   <= (w_state_nxt == ST_ERROR);
      r_timeout <= i_en && (r_timeout || w_timeout_hit);
    end
  end

  //--------------------------------------------------------------------------
  // Sideband arbitration with a one-entry hold buffer. While an entry is
  // held, any new request is dropped, even in the cycle the entry drains.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg      <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_msg <= '0;
    end else begin
      r_valid <= 1'b0;
      if (!i_en) begin
        r_pend_vld <= 1'b0;
      end else if (r_pend_vld) begin
        if (w_accept) begin
          r_ovf <= 1'b1;
        end
        if (!i_busy) begin
          r_msg      <= r_pend_msg;
          r_valid    <= 1'b1;
          r_pend_vld <= 1'b0;
        end
      end else if (w_accept) begin
        if (!i_busy) begin
          r_msg   <= w_cur_msg;
          r_valid <= 1'b1;
        end else begin
          r_pend_msg <= w_cur_msg;
          r_pend_vld <= 1'b1;
        end
      end
    end
  end

  assign o_sub_en                    = r_sub_en;
  assign o_mainband_or_valtrain_test = r_mb;
  assign o_sideband_message          = r_msg;
  assign o_valid                     = r_valid;
  assign o_done                      = r_done;
  assign o_error                     = r_error;
  assign o_timeout                   = r_timeout;
  assign o_sb_overflow               = r_ovf;
  assign o_state                     = r_state;

endmodule : mbtrain_substate_sequencer
`default_nettype wire

// File: tb/tb_mbtrain_substate_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_mbtrain_substate_sequencer
// Description : Directed self-checking bench for the MBTRAIN sub-state
//               sequencer, built with TIMEOUT_CYCLES = 16.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_mbtrain_substate_sequencer;

  localparam int N_SUB = 6;
  localparam int TOC   = 16;

  logic             clk;
  logic             rst_n;
  logic             i_en;
  logic [N_SUB-1:0] i_sub_done;
  logic [N_SUB-1:0] i_sub_error;
  logic [N_SUB-1:0] i_sub_valid;
  logic [4*N_SUB-1:0] i_sub_msg;
  logic             i_busy;
  logic [N_SUB-1:0] o_sub_en;
  logic             o_mb;
  logic [3:0]       o_sideband_message;
  logic             o_valid;
  logic             o_done;
  logic             o_error;
  logic             o_timeout;
  logic             o_sb_overflow;
  logic [2:0]       o_state;

  int n_vec;
  int n_err;

  mbtrain_substate_sequencer #(
    .N_SUB          (N_SUB),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .i_en                        (i_en),
    .i_sub_done                  (i_sub_done),
    .i_sub_error                 (i_sub_error),
    .i_sub_valid                 (i_sub_valid),
    .i_sub_msg                   (i_sub_msg),
    .i_busy                      (i_busy),
    .o_sub_en                    (o_sub_en),
    .o_mainband_or_valtrain_test (o_mb),
    .o_sideband_message          (o_sideband_message),
    .o_valid                     (o_valid),
    .o_done                      (o_done),
    .o_error                     (o_error),
    .o_timeout                   (o_timeout),
    .o_sb_overflow               (o_sb_overflow),
    .o_state                     (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // From the first cycle of RUN at idx 0, walk forward to RUN at idx n.
  task automatic goto_idx(input int n);
    for (int j = 0; j < n; j++) begin
      i_sub_done[j] = 1'b1;
      tick();
      i_sub_done[j] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_en = 1'b0; i_busy = 1'b0;
    i_sub_done = '0; i_sub_error = '0; i_sub_valid = '0; i_sub_msg = '0;
    repeat (3) tick();
    n_vec++;
    if ({o_sub_en, o_mb, o_sideband_message, o_valid, o_done, o_error,
         o_timeout, o_sb_overflow, o_state} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: sub_en=%b mb=%b msg=%h v=%b d=%b e=%b t=%b ovf=%b st=%0d, required all 0",
               o_sub_en, o_mb, o_sideband_message, o_valid, o_done, o_error,
               o_timeout, o_sb_overflow, o_state);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (o_state !== 3'd0) begin
      n_err++; $display("FAIL reset_idle: state=%0d required 0", o_state);
    end
  endtask

  task automatic test_happy_path();
    logic [N_SUB-1:0] exp_en;
    i_en = 1'b1;
    tick();
    n_vec++;
    if (o_sub_en !== 6'b000001 || o_mb !== 1'b1 || o_state !== 3'd1) begin
      n_err++;
      $display("FAIL happy_start: sub_en=%b mb=%b st=%0d required 000001 1 1", o_sub_en, o_mb, o_state);
    end
    for (int k = 0; k < N_SUB; k++) begin
      tick(); tick();
      i_sub_done[k] = 1'b1;
      tick();
      i_sub_done[k] = 1'b0;
      if (k < N_SUB - 1) begin
        n_vec++;
        if (o_sub_en !== 6'b0 || o_state !== 3'd2 || o_mb !== 1'b0) begin
          n_err++;
          $display("FAIL happy_gap%0d: sub_en=%b st=%0d mb=%b required 0 2 0", k, o_sub_en, o_state, o_mb);
        end
        tick();
        exp_en = 6'b1 << (k + 1);
        n_vec++;
        if (o_sub_en !== exp_en || o_mb !== ((k + 1) == 5)) begin
          n_err++;
          $display("FAIL happy_en%0d: sub_en=%b mb=%b required %b %b", k + 1, o_sub_en, o_mb, exp_en, ((k + 1) == 5));
        end
      end else begin
        n_vec++;
        if (o_done !== 1'b1 || o_sub_en !== 6'b0 || o_state !== 3'd3 || o_error !== 1'b0) begin
          n_err++;
          $display("FAIL happy_done: done=%b sub_en=%b st=%0d err=%b required 1 0 3 0", o_done, o_sub_en, o_state, o_error);
        end
      end
    end
    tick();
    n_vec++;
    if (o_done !== 1'b1 || o_state !== 3'd3) begin
      n_err++; $display("FAIL happy_done_hold: done=%b st=%0d required 1 3", o_done, o_state);
    end
    i_en = 1'b0;
    tick();
    n_vec++;
    if (o_done !== 1'b0 || o_state !== 3'd0) begin
      n_err++; $display("FAIL happy_exit: done=%b st=%0d required 0 0", o_done, o_state);
    end
  endtask

  task automatic test_timeout();
    i_en = 1'b1;
    tick();
    goto_idx(2);
    n_vec++;
    if (o_sub_en !== 6'b000100) begin
      n_err++; $display("FAIL to_en2: sub_en=%b required 000100", o_sub_en);
    end
    repeat (TOC - 1) tick();
    n_vec++;
    if (o_error !== 1'b0 || o_sub_en !== 6'b000100) begin
      n_err++; $display("FAIL to_early: err=%b sub_en=%b required 0 000100", o_error, o_sub_en);
    end
    tick();
    n_vec++;
    if (o_error !== 1'b1 || o_timeout !== 1'b1 || o_sub_en !== 6'b0 || o_state !== 3'd4) begin
      n_err++;
      $display("FAIL to_fire: err=%b to=%b sub_en=%b st=%0d required 1 1 0 4", o_error, o_timeout, o_sub_en, o_state);
    end
    i_en = 1'b0;
    tick();
    n_vec++;
    if (o_error !== 1'b0 || o_timeout !== 1'b0 || o_state !== 3'd0) begin
      n_err++; $display("FAIL to_clear: err=%b to=%b st=%0d required 0 0 0", o_error, o_timeout, o_state);
    end
  endtask

  task automatic test_priority();
    // done on the very cycle the timer expires: done wins
    i_en = 1'b1;
    tick();
    repeat (TOC - 1) tick();
    i_sub_done[0] = 1'b1;
    tick();
    i_sub_done[0] = 1'b0;
    n_vec++;
    if (o_state !== 3'd2 || o_error !== 1'b0) begin
      n_err++; $display("FAIL prio_done_vs_to: st=%0d err=%b required 2 0", o_state, o_error);
    end
    tick();
    // inactive done ignored
    i_sub_done[3] = 1'b1;
    tick(); tick();
    n_vec++;
    if (o_sub_en !== 6'b000010 || o_state !== 3'd1) begin
      n_err++; $display("FAIL prio_inactive: sub_en=%b st=%0d required 000010 1", o_sub_en, o_state);
    end
    i_sub_done[3]  = 1'b0;
    i_sub_done[1]  = 1'b1;
    i_sub_error[1] = 1'b1;
    tick();
    i_sub_done[1]  = 1'b0;
    i_sub_error[1] = 1'b0;
    n_vec++;
    if (o_error !== 1'b1 || o_timeout !== 1'b0 || o_state !== 3'd4 || o_sub_en !== 6'b0) begin
      n_err++;
      $display("FAIL prio_err_vs_done: err=%b to=%b st=%0d sub_en=%b required 1 0 4 0", o_error, o_timeout, o_state, o_sub_en);
    end
    i_en = 1'b0;
    tick();
  endtask

  task automatic test_sideband();
    i_en = 1'b1;
    tick();
    i_busy = 1'b1;
    i_sub_valid[0] = 1'b1; i_sub_msg[3:0] = 4'hA;
    tick();
    i_sub_valid[0] = 1'b0;
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++; $display("FAIL sb_busy_hold: valid=%b required 0", o_valid);
    end
    i_sub_valid[0] = 1'b1; i_sub_msg[3:0] = 4'h5;
    tick();
    i_sub_valid[0] = 1'b0;
    n_vec++;
    if (o_valid !== 1'b0 || o_sb_overflow !== 1'b1) begin
      n_err++; $display("FAIL sb_overflow: valid=%b ovf=%b required 0 1", o_valid, o_sb_overflow);
    end
    i_busy = 1'b0;
    tick();
    n_vec++;
    if (o_valid !== 1'b1 || o_sideband_message !== 4'hA) begin
      n_err++; $display("FAIL sb_release: valid=%b msg=%h required 1 a", o_valid, o_sideband_message);
    end
    tick();
    n_vec++;
    if (o_valid !== 1'b0 || o_sideband_message !== 4'hA) begin
      n_err++; $display("FAIL sb_pulse: valid=%b msg=%h required 0 a", o_valid, o_sideband_message);
    end
    i_sub_valid[0] = 1'b1; i_sub_msg[3:0] = 4'h3;
    tick();
    i_sub_valid[0] = 1'b0;
    n_vec++;
    if (o_valid !== 1'b1 || o_sideband_message !== 4'h3) begin
      n_err++; $display("FAIL sb_direct: valid=%b msg=%h required 1 3", o_valid, o_sideband_message);
    end
    i_sub_valid[2] = 1'b1; i_sub_msg[11:8] = 4'h7;
    tick();
    i_sub_valid[2] = 1'b0;
    tick();
    n_vec++;
    if (o_valid !== 1'b0 || o_sideband_message !== 4'h3) begin
      n_err++; $display("FAIL sb_inactive: valid=%b msg=%h required 0 3", o_valid, o_sideband_message);
    end
    i_en = 1'b0;
    tick();
    n_vec++;
    if (o_sb_overflow !== 1'b1) begin
      n_err++; $display("FAIL sb_ovf_sticky: ovf=%b required 1", o_sb_overflow);
    end
  endtask

  task automatic test_abort();
    i_en = 1'b1;
    tick();
    goto_idx(3);
    i_busy = 1'b1;
    i_sub_valid[3] = 1'b1; i_sub_msg[15:12] = 4'h9;
    tick();
    i_sub_valid[3] = 1'b0;
    i_en = 1'b0;
    i_busy = 1'b0;
    tick();
    n_vec++;
    if (o_state !== 3'd0 || o_sub_en !== 6'b0 || o_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: st=%0d sub_en=%b valid=%b required 0 0 0", o_state, o_sub_en, o_valid);
    end
    i_en = 1'b1;
    tick();
    n_vec++;
    if (o_state !== 3'd1 || o_sub_en !== 6'b000001 || o_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_restart: st=%0d sub_en=%b valid=%b required 1 000001 0", o_state, o_sub_en, o_valid);
    end
    tick();
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_flushed: valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_sub_en, o_mb, o_sideband_message, o_valid, o_done, o_error,
         o_timeout, o_sb_overflow, o_state} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: sub_en=%b mb=%b msg=%h v=%b ovf=%b st=%0d required all 0",
               o_sub_en, o_mb, o_sideband_message, o_valid, o_sb_overflow, o_state);
    end
    i_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_happy_path();
    test_timeout();
    test_priority();
    test_sideband();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mbtrain_substate_sequencer
`default_nettype wire
